pwm_decode: RTL
===============

PWM_DECODE -- requirements
Module: pwm_decode

Interface
REQ-001 Parameter: CW, default 11, width of the cycle counters; timeout limit TMAX = 2^CW - 1 (2047).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pwm_in  input  1  PWM line, asynchronous to clk.
REQ-005 code_out  output  CW-1  recovered duty code (pwm data_in equivalent), registered.
REQ-006 high_len  output  CW  high-phase length of last measured period, in clk cycles, registered.
REQ-007 period_out  output  CW  rise-to-rise length of last measured period, in clk cycles, registered.
REQ-008 valid  output  1  one-cycle strobe; code_out/high_len/period_out/stuck updated in that cycle.
REQ-009 stuck  output  1  level; 1 = line held constant for TMAX cycles.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3; rise = s2 & ~s3, fall = ~s2 & s3; no other logic SHALL use pwm_in directly.
REQ-011 FSM states: IDLE, HIGH, LOW; one cnt_p (period) and one cnt_h (high) counter, both CW bits.
REQ-012 IDLE: cnt_p increments each cycle; on rise -> HIGH with cnt_p = 1, cnt_h = 1, no valid.
REQ-013 HIGH: cnt_p and cnt_h increment; on fall -> LOW (cnt_h frozen).
REQ-014 LOW: cnt_p increments; on rise -> publish, then HIGH with cnt_p = 1, cnt_h = 1.
REQ-015 Publish: high_len <= cnt_h, period_out <= cnt_p, code_out <= cnt_h - 1 saturated to 2^(CW-1) - 1, stuck <= 0, valid <= 1 for exactly one cycle.
REQ-016 Latency: valid SHALL be high in the cycle following the 2nd clk rising edge after the edge at which s1 first samples the closing high level.
REQ-017 Measurement is by s2, so a generator high time of d+1 cycles and period 1024 SHALL yield high_len = d+1, code_out = d, period_out = 1024.
REQ-018 Timeout: when cnt_p reaches TMAX in any state without a publishing rise, the block SHALL publish with stuck <= 1, high_len <= 0, period_out <= 0, and code_out <= all-ones if s2 = 1 else 0; valid pulses once; FSM -> IDLE with cnt_p held at TMAX (no further valid) until the next rise.
REQ-019 After a timeout, the first rise re-enters HIGH without publishing; stuck SHALL remain 1 until the next normal publish.
REQ-020 Counters SHALL never wrap; cnt_p saturates at TMAX.
REQ-021 Rise and timeout on the same edge: rise takes priority (normal publish).
REQ-022 A change of pwm period/duty mid-stream SHALL be reported as measured; no filtering or averaging.

Reset
REQ-023 rst = 1 SHALL immediately force: s1, s2, s3 = 0; FSM = IDLE; cnt_p, cnt_h = 0; code_out, high_len, period_out = 0; valid = 0; stuck = 0.
REQ-024 Reset mid-measurement SHALL discard the partial period; no valid is produced for it after release.
REQ-025 After release, the first valid SHALL occur only after two rises (or a timeout).

Verification
REQ-026 rst pulse asserted between clk edges while valid = 1 and stuck = 1 -> all outputs 0 before the next clk edge.
REQ-027 Stimulus = pwm generator, data_in 300, period 1024 -> valid once per 1024 cycles, code_out = 300, high_len = 301, period_out = 1024, stuck = 0; check latency per REQ-016.
REQ-028 Generator data_in 0 then 1022 -> code_out 0 / high_len 1, then code_out 1022 / high_len 1023, period_out 1024 in both.
REQ-029 pwm_in held 0 from reset release -> single valid at cycle TMAX, code_out = 0, stuck = 1; repeat with pwm_in held 1 -> code_out = 1023, stuck = 1; no second valid.
REQ-030 Low phase of 3000 cycles after a normal period -> timeout publish with code_out = 0, stuck = 1; next two rises 1024 apart -> normal publish, stuck = 0.
REQ-031 rst asserted during HIGH of period with data_in 500, released, then data_in 700 -> no valid with data 500 after release; first valid reports code_out = 700.

Source files
------------

// File: rtl/pwm_decode.sv
// pwm_decode: recovers the duty code, high time and period of a PWM line.
// The line is synchronised and then measured rise-to-rise in clk cycles.
// A line that stays constant for TMAX cycles is reported once as stuck.
module pwm_decode #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-2:0] code_out,
    output logic [CW-1:0] high_len,
    output logic [CW-1:0] period_out,
    output logic          valid,
    output logic          stuck
);

    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TMAX     = {CW{1'b1}};
    localparam logic [CW-1:0] TMAX_M1  = TMAX - ONE;
    localparam logic [CW-2:0] CODE_MAX = {(CW-1){1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic          rise, fall;
    logic [CW-1:0] cnt_p_q, cnt_p_d;
    logic [CW-1:0] cnt_h_q, cnt_h_d;
    logic [CW-1:0] cnt_p_inc;
    logic [CW-1:0] code_full;
    logic          timeout;
    logic          pub_normal, pub_timeout;
    logic [CW-2:0] code_q, code_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;

    // Two-flop synchroniser plus a history flop for edge detection.
    // NOTE: sequential state always uses <=, so every flop samples the pre-edge
    // value of its neighbour; = here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // State and measurement counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_p_q <= '0;
            cnt_h_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_p_q <= cnt_p_d;
            cnt_h_q <= cnt_h_d;
        end
    end

    // Next-state logic: measure high phase and period, detect the stuck line.
    // A timeout fires on the edge that would take cnt_p to TMAX; once in IDLE
    // with cnt_p parked at TMAX it can never fire again until a rise.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_p_d     = cnt_p_q;
        cnt_h_d     = cnt_h_q;
        pub_normal  = 1'b0;
        pub_timeout = 1'b0;
        cnt_p_inc   = (cnt_p_q == TMAX) ? TMAX : cnt_p_q + ONE;
        timeout     = (cnt_p_q == TMAX_M1);

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_p_d = ONE;
                    cnt_h_d = ONE;
                end else if (timeout) begin
                    pub_timeout = 1'b1;
                    cnt_p_d     = TMAX;
                end else begin
                    cnt_p_d = cnt_p_inc;
                end
            end
            HIGH: begin
                if (timeout) begin
                    pub_timeout = 1'b1;
                    state_d     = IDLE;
                    cnt_p_d     = TMAX;
                end else begin
                    cnt_p_d = cnt_p_inc;
                    if (fall) begin
                        state_d = LOW;
                    end else begin
                        cnt_h_d = cnt_h_q + ONE;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    pub_normal = 1'b1;
                    state_d    = HIGH;
                    cnt_p_d    = ONE;
                    cnt_h_d    = ONE;
                end else if (timeout) begin
                    pub_timeout = 1'b1;
                    state_d     = IDLE;
                    cnt_p_d     = TMAX;
                end else begin
                    cnt_p_d = cnt_p_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_p_d = '0;
                cnt_h_d = '0;
            end
        endcase
    end

    // Result selection: a normal publish reports the measurement, a timeout
    // reports the stuck level; otherwise results hold.
    always_comb begin
        code_full = cnt_h_q - ONE;
        valid_d   = pub_normal | pub_timeout;
        code_d    = code_q;
        high_d    = high_q;
        period_d  = period_q;
        stuck_d   = stuck_q;
        if (pub_normal) begin
            high_d   = cnt_h_q;
            period_d = cnt_p_q;
            code_d   = code_full[CW-1] ? CODE_MAX : code_full[CW-2:0];
            stuck_d  = 1'b0;
        end else if (pub_timeout) begin
            high_d   = '0;
            period_d = '0;
            code_d   = s2_q ? CODE_MAX : '0;
            stuck_d  = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            code_q   <= code_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign code_out   = code_q;
    assign high_len   = high_q;
    assign period_out = period_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;

endmodule
